// File: rtl/regex_cmd_sequencer_pkg.sv
// rtl/regex_cmd_sequencer_pkg.sv - coprocessor command/status codes, register widths and sequencer enums
package AXI_package;

   localparam int unsigned REG_WIDTH    = 32;
   localparam int unsigned REG_WIDTH_64 = 64;

   localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
   localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
   localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd2;
   localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd3;
   localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 32'd4;
   localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd5;

   localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
   localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
   localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
   localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
   localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

   typedef enum logic [3:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_FENCE,
      SEQ_START,
      SEQ_RUN,
      SEQ_READCC,
      SEQ_RESTART,
      SEQ_DONE,
      SEQ_ABORT
   } seq_state_t;

   typedef enum logic [1:0] {
      RES_ACCEPT  = 2'd0,
      RES_REJECT  = 2'd1,
      RES_ERROR   = 2'd2,
      RES_TIMEOUT = 2'd3
   } seq_res_code_t;

   function automatic logic is_terminal(input logic [REG_WIDTH-1:0] status);
      return (status == STATUS_ACCEPTED) || (status == STATUS_REJECTED) ||
             (status == STATUS_ERROR);
   endfunction

   function automatic seq_res_code_t status_to_code(input logic [REG_WIDTH-1:0] status);
      seq_res_code_t code;
      code = RES_ERROR;
      if (status == STATUS_ACCEPTED) begin
         code = RES_ACCEPT;
      end else if (status == STATUS_REJECTED) begin
         code = RES_REJECT;
      end
      return code;
   endfunction

endpackage

// File: rtl/regex_cmd_sequencer_watchdog.sv
// rtl/regex_cmd_sequencer_watchdog.sv - saturating cycle counter flagging expiry at all-ones
module seq_watchdog #(
   parameter int unsigned WIDTH = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !(&count_q)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = &count_q;

endmodule

// File: rtl/regex_cmd_sequencer.sv
// rtl/regex_cmd_sequencer.sv - loads a program into the coprocessor, runs it and returns a result record
// Optional watchdog: REGEX_CMD_SEQ_TIMEOUT_EN
module regex_cmd_sequencer
   import AXI_package::*;
#(
   parameter int unsigned ADDR_WIDTH    = 9,
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned TIMEOUT_WIDTH = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [ADDR_WIDTH-1:0]   job_base_addr,
   input  logic [ADDR_WIDTH:0]     job_len,
   input  logic [REG_WIDTH-1:0]    job_start_cc,
   input  logic [REG_WIDTH-1:0]    job_end_cc,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [1:0]              res_code,
   output logic [REG_WIDTH-1:0]    res_cycles,
   output logic [REG_WIDTH-1:0]    cmd_register,
   output logic [REG_WIDTH-1:0]    address_register,
   output logic [REG_WIDTH_64-1:0] data_in_register,
   output logic [REG_WIDTH-1:0]    start_cc_pointer_register,
   output logic [REG_WIDTH-1:0]    end_cc_pointer_register,
   input  logic [REG_WIDTH-1:0]    status_register,
   input  logic [REG_WIDTH_64-1:0] data_o_register
);

   seq_state_t              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [ADDR_WIDTH:0]     idx_q, idx_d;
   seq_res_code_t           code_q, code_d;
   logic [REG_WIDTH-1:0]    cycles_q, cycles_d;
   logic [REG_WIDTH-1:0]    cmd_q, cmd_d;
   logic [REG_WIDTH-1:0]    address_q, address_d;
   logic [REG_WIDTH_64-1:0] data_q, data_d;
   logic [REG_WIDTH-1:0]    start_cc_q, start_cc_d;
   logic [REG_WIDTH-1:0]    end_cc_q, end_cc_d;
   logic                    job_ready_q, job_ready_d;
   logic                    wr_ready_q, wr_ready_d;
   logic                    res_valid_q, res_valid_d;

   logic [ADDR_WIDTH-1:0]   addr_sum;
   logic                    in_watch;
   logic                    wd_clear;
   logic                    wd_expired;
   logic                    unused_data_hi;

   // Only the low register word of the read data carries the elapsed count.
   assign unused_data_hi = ^data_o_register[REG_WIDTH_64-1:REG_WIDTH];

   assign in_watch = (state_q == SEQ_START) || (state_q == SEQ_RUN) ||
                     (state_q == SEQ_RESTART);
   assign wd_clear = (state_q == SEQ_FENCE);

`ifdef REGEX_CMD_SEQ_TIMEOUT_EN
   seq_watchdog #(
      .WIDTH (TIMEOUT_WIDTH)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (in_watch),
      .expired (wd_expired)
   );
`else
   localparam int unsigned UNUSED_TIMEOUT_WIDTH = TIMEOUT_WIDTH;
   logic unused_wd;
   assign unused_wd  = wd_clear;
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      idx_d      = idx_q;
      code_d     = code_q;
      cycles_d   = cycles_q;
      cmd_d      = CMD_NOP;
      address_d  = address_q;
      data_d     = data_q;
      start_cc_d = start_cc_q;
      end_cc_d   = end_cc_q;
      addr_sum   = base_q + idx_q[ADDR_WIDTH-1:0];

      unique case (state_q)
         SEQ_IDLE: begin
            if (job_ready_q && job_valid) begin
               base_d     = job_base_addr;
               len_d      = job_len;
               idx_d      = '0;
               start_cc_d = job_start_cc;
               end_cc_d   = job_end_cc;
               state_d    = (job_len != '0) ? SEQ_LOAD : SEQ_FENCE;
            end
         end
         SEQ_LOAD: begin
            if (wr_ready_q && wr_valid) begin
               cmd_d     = CMD_WRITE;
               address_d = REG_WIDTH'(addr_sum);
               data_d    = REG_WIDTH_64'(wr_data);
               idx_d     = idx_q + 1'b1;
               if (idx_d == len_q) begin
                  state_d = SEQ_FENCE;
               end
            end
         end
         SEQ_FENCE: begin
            state_d = SEQ_START;
         end
         SEQ_START: begin
            if (status_register == STATUS_RUNNING) begin
               state_d = SEQ_RUN;
            end else begin
               cmd_d = CMD_START;
            end
         end
         SEQ_RUN: begin
            if (is_terminal(status_register)) begin
               code_d  = status_to_code(status_register);
               cmd_d   = CMD_READ_ELAPSED_CLOCK;
               state_d = SEQ_READCC;
            end
         end
         SEQ_READCC: begin
            // The read command is on the bus this cycle, so the read data is valid now.
            cycles_d = data_o_register[REG_WIDTH-1:0];
            cmd_d    = CMD_RESTART;
            state_d  = SEQ_RESTART;
         end
         SEQ_RESTART: begin
            if (status_register == STATUS_IDLE) begin
               state_d = SEQ_DONE;
            end else begin
               cmd_d = CMD_RESTART;
            end
         end
         SEQ_DONE: begin
            if (res_valid_q && res_ready) begin
               state_d = SEQ_IDLE;
            end
         end
         SEQ_ABORT: begin
            state_d = SEQ_DONE;
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase

      if (wd_expired && in_watch) begin
         cmd_d    = CMD_RESET;
         code_d   = RES_TIMEOUT;
         cycles_d = '0;
         state_d  = SEQ_ABORT;
      end

      job_ready_d = (state_d == SEQ_IDLE);
      wr_ready_d  = (state_d == SEQ_LOAD);
      res_valid_d = (state_d == SEQ_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SEQ_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         code_q      <= RES_ACCEPT;
         cycles_q    <= '0;
         cmd_q       <= CMD_NOP;
         address_q   <= '0;
         data_q      <= '0;
         start_cc_q  <= '0;
         end_cc_q    <= '0;
         job_ready_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         code_q      <= code_d;
         cycles_q    <= cycles_d;
         cmd_q       <= cmd_d;
         address_q   <= address_d;
         data_q      <= data_d;
         start_cc_q  <= start_cc_d;
         end_cc_q    <= end_cc_d;
         job_ready_q <= job_ready_d;
         wr_ready_q  <= wr_ready_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign job_ready                 = job_ready_q;
   assign wr_ready                  = wr_ready_q;
   assign res_valid                 = res_valid_q;
   assign res_code                  = code_q;
   assign res_cycles                = cycles_q;
   assign cmd_register              = cmd_q;
   assign address_register          = address_q;
   assign data_in_register          = data_q;
   assign start_cc_pointer_register = start_cc_q;
   assign end_cc_pointer_register   = end_cc_q;

endmodule

// File: tb/tb_regex_cmd_sequencer.sv
// tb/tb_regex_cmd_sequencer.sv - scoreboard bench for regex_cmd_sequencer with a coprocessor status model
module tb_regex_cmd_sequencer;
   import AXI_package::*;

`ifdef REGEX_CMD_SEQ_TIMEOUT_EN
   localparam int unsigned TW = 6;
`else
   localparam int unsigned TW = 20;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
   } wr_t;

   typedef struct {
      logic [1:0]  code;
      logic [31:0] cycles;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        job_valid, job_ready;
   logic [8:0]  job_base_addr;
   logic [9:0]  job_len;
   logic [31:0] job_start_cc, job_end_cc;
   logic        wr_valid, wr_ready;
   logic [63:0] wr_data;
   logic        res_valid, res_ready;
   logic [1:0]  res_code;
   logic [31:0] res_cycles;
   logic [31:0] cmd_register, address_register;
   logic [63:0] data_in_register;
   logic [31:0] start_cc_pointer_register, end_cc_pointer_register;
   logic [31:0] status_register;
   logic [63:0] data_o_register;

   int checks = 0;
   int errors = 0;
   int start_phases = 0;
   int reset_cycles = 0;
   wr_t  exp_wr[$];
   res_t exp_res[$];

   logic [31:0] m_status, m_elapsed, m_run_len, m_term;
   logic        m_hang;
   logic [31:0] prev_cmd;
   logic        prev_res_valid;

   always #5 clk = ~clk;

   regex_cmd_sequencer #(
      .ADDR_WIDTH    (9),
      .DATA_WIDTH    (64),
      .TIMEOUT_WIDTH (TW)
   ) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .job_valid                 (job_valid),
      .job_ready                 (job_ready),
      .job_base_addr             (job_base_addr),
      .job_len                   (job_len),
      .job_start_cc              (job_start_cc),
      .job_end_cc                (job_end_cc),
      .wr_valid                  (wr_valid),
      .wr_ready                  (wr_ready),
      .wr_data                   (wr_data),
      .res_valid                 (res_valid),
      .res_ready                 (res_ready),
      .res_code                  (res_code),
      .res_cycles                (res_cycles),
      .cmd_register              (cmd_register),
      .address_register          (address_register),
      .data_in_register          (data_in_register),
      .start_cc_pointer_register (start_cc_pointer_register),
      .end_cc_pointer_register   (end_cc_pointer_register),
      .status_register           (status_register),
      .data_o_register           (data_o_register)
   );

   // Coprocessor model: runs m_run_len cycles after START, then reports m_term.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_status  <= STATUS_IDLE;
         m_elapsed <= 32'd0;
      end else if (cmd_register == CMD_RESET) begin
         m_status <= STATUS_IDLE;
      end else if (m_status == STATUS_IDLE) begin
         if (cmd_register == CMD_START) begin
            m_status  <= STATUS_RUNNING;
            m_elapsed <= 32'd0;
         end
      end else if (m_status == STATUS_RUNNING) begin
         m_elapsed <= m_elapsed + 32'd1;
         if (!m_hang && (m_elapsed + 32'd1 == m_run_len)) m_status <= m_term;
      end else if (cmd_register == CMD_RESTART) begin
         m_status <= STATUS_IDLE;
      end
   end

   assign status_register = m_status;
   assign data_o_register = (cmd_register == CMD_READ_ELAPSED_CLOCK) ?
                            {32'hA5A5_A5A5, m_elapsed} : 64'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write or a new result.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_register == CMD_WRITE) begin
            check("write_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
               wr_t e;
               e = exp_wr.pop_front();
               check("wr_addr", address_register, e.addr);
               check("wr_data", data_in_register, e.data);
            end
         end
         if (cmd_register == CMD_START && prev_cmd != CMD_START) start_phases++;
         if (cmd_register == CMD_RESET) reset_cycles++;
         if (res_valid && !prev_res_valid) begin
            check("res_expected", exp_res.size() != 0, 1);
            if (exp_res.size() != 0) begin
               res_t r;
               r = exp_res.pop_front();
               check("res_code", res_code, r.code);
               check("res_cycles", res_cycles, r.cycles);
            end
         end
      end
      prev_cmd       <= cmd_register;
      prev_res_valid <= res_valid;
   end

   task automatic issue_job(input logic [8:0] base, input logic [9:0] len,
                            input logic [31:0] sc, input logic [31:0] ec);
      int n = 0;
      job_base_addr = base;
      job_len       = len;
      job_start_cc  = sc;
      job_end_cc    = ec;
      job_valid     = 1'b1;
      while (!job_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("job_accept_bound", n < 200, 1);
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] addr, input logic [63:0] d);
      int n = 0;
      exp_wr.push_back('{addr, d});
      wr_data  = d;
      wr_valid = 1'b1;
      while (!wr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("word_accept_bound", n < 200, 1);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(res_valid && res_ready) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("done_bound", n < 3000, 1);
      @(negedge clk);
   endtask

   initial begin
      int s0;
      int n;
      job_valid = 0; job_base_addr = '0; job_len = '0; job_start_cc = '0; job_end_cc = '0;
      wr_valid = 0; wr_data = '0; res_ready = 1'b1;
      m_run_len = 32'd50; m_term = STATUS_ACCEPTED; m_hang = 1'b0;
      prev_cmd = CMD_NOP; prev_res_valid = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_cmd", cmd_register, CMD_NOP);
      check("rst_job_ready", job_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_addr", address_register, 0);
      check("rst_data", data_in_register, 0);
      check("rst_res", {res_code, res_cycles}, 0);
      check("rst_ptrs", {start_cc_pointer_register, end_cc_pointer_register}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("job_ready_after_reset", job_ready, 1);

      // Load four words and accept after 50 cycles
      m_run_len = 32'd50; m_term = STATUS_ACCEPTED;
      exp_res.push_back('{2'd0, 32'd50});
      s0 = start_phases;
      issue_job(9'h010, 10'd4, 32'h0000_AAAA, 32'h0000_BBBB);
      check("start_cc_ptr", start_cc_pointer_register, 32'h0000_AAAA);
      check("end_cc_ptr", end_cc_pointer_register, 32'h0000_BBBB);
      for (int i = 0; i < 4; i++) push_word(32'h10 + i, 64'h11 * (i + 1));
      wait_done();
      check("start_phases", start_phases - s0, 1);
      check("status_idle_at_end", status_register, STATUS_IDLE);

      // Backpressure gaps with address wrap, rejected
      m_run_len = 32'd5; m_term = STATUS_REJECTED;
      exp_res.push_back('{2'd1, 32'd5});
      issue_job(9'h1FE, 10'd3, 32'd1, 32'd2);
      push_word(32'h1FE, 64'hDEAD_0000_0000_0001);
      @(negedge clk);
      check("gap1_nop", cmd_register, CMD_NOP);
      check("gap1_addr_hold", address_register, 32'h1FE);
      push_word(32'h1FF, 64'hDEAD_0000_0000_0002);
      @(negedge clk);
      check("gap2_nop", cmd_register, CMD_NOP);
      check("gap2_data_hold", data_in_register, 64'hDEAD_0000_0000_0002);
      push_word(32'h000, 64'hDEAD_0000_0000_0003);
      wait_done();

      // Empty job, coprocessor errors
      m_run_len = 32'd3; m_term = STATUS_ERROR;
      exp_res.push_back('{2'd2, 32'd3});
      issue_job(9'h055, 10'd0, 32'd3, 32'd4);
      check("empty_no_wr_ready", wr_ready, 0);
      wait_done();

      // Result held while res_ready is low
      m_run_len = 32'd7; m_term = STATUS_ACCEPTED;
      exp_res.push_back('{2'd0, 32'd7});
      res_ready = 1'b0;
      issue_job(9'h100, 10'd1, 32'd5, 32'd6);
      push_word(32'h100, 64'h0123_4567_89AB_CDEF);
      n = 0;
      while (!res_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("hold_valid_bound", n < 500, 1);
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", res_valid, 1);
         check("hold_code", res_code, 2'd0);
         check("hold_cycles", res_cycles, 32'd7);
         check("hold_job_ready", job_ready, 0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      wait_done();
      check("job_ready_after_hs", job_ready, 1);

      // Reset while the coprocessor is running
      m_run_len = 32'd1000; m_term = STATUS_ACCEPTED;
      issue_job(9'h020, 10'd1, 32'd7, 32'd8);
      push_word(32'h020, 64'h5555);
      n = 0;
      while (m_status != STATUS_RUNNING && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("run_reached_bound", n < 100, 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_cmd", cmd_register, CMD_NOP);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_job_ready", job_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("job_ready_after_midrst", job_ready, 1);
      m_run_len = 32'd10; m_term = STATUS_ACCEPTED;
      exp_res.push_back('{2'd0, 32'd10});
      issue_job(9'h030, 10'd2, 32'd9, 32'd10);
      push_word(32'h030, 64'hA1);
      push_word(32'h031, 64'hA2);
      wait_done();

`ifdef REGEX_CMD_SEQ_TIMEOUT_EN
      // Coprocessor never finishes: watchdog must fire once
      m_hang = 1'b1;
      exp_res.push_back('{2'd3, 32'd0});
      s0 = reset_cycles;
      issue_job(9'h000, 10'd0, 32'd0, 32'd0);
      wait_done();
      check("timeout_reset_cycles", reset_cycles - s0, 1);
      m_hang = 1'b0;
`endif

      check("wr_queue_drained", exp_wr.size(), 0);
      check("res_queue_drained", exp_res.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
